// File: rtl/matmul_result_scratchpad_if.sv
// Signal bundle between the matmul calc unit / host and the result scratchpad.
// The slave modport is the scratchpad side; the master modport is its driver.
interface matmul_result_scratchpad_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SP_NTARGETS = 4
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int IDXW    = 2 * $clog2(MAX_DIM);
    localparam int BW      = $clog2(SP_NTARGETS);

    logic                   wr_en_i;
    logic [ADDR_WIDTH-1:0]  wr_addr_i;
    logic [BUS_WIDTH-1:0]   wr_data_i;
    logic [BW-1:0]          wr_bank_i;
    logic                   finish_mul_i;
    logic                   rd_req_i;
    logic [BW-1:0]          rd_bank_i;
    logic [BUS_WIDTH-1:0]   rd_data_o;
    logic                   rd_valid_o;
    logic                   finished_c_o;
    logic                   host_rd_en_i;
    logic [BW+IDXW-1:0]     host_addr_i;
    logic [BUS_WIDTH-1:0]   host_rd_data_o;
    logic                   host_rd_valid_o;
    logic [SP_NTARGETS-1:0] bank_valid_o;
    logic                   err_o;

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_bank_i, finish_mul_i,
        input  rd_req_i, rd_bank_i, host_rd_en_i, host_addr_i,
        output rd_data_o, rd_valid_o, finished_c_o,
        output host_rd_data_o, host_rd_valid_o, bank_valid_o, err_o
    );

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_bank_i, finish_mul_i,
        output rd_req_i, rd_bank_i, host_rd_en_i, host_addr_i,
        input  rd_data_o, rd_valid_o, finished_c_o,
        input  host_rd_data_o, host_rd_valid_o, bank_valid_o, err_o
    );
endinterface

// File: rtl/matmul_result_scratchpad.sv
// Banked result store for the matmul calc unit: captures result bursts, replays a
// bank as the C-bias stream, and offers a 1-cycle host readback port.
module matmul_result_scratchpad #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SP_NTARGETS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    matmul_result_scratchpad_if.slave sp
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int NELEM   = MAX_DIM * MAX_DIM;
    localparam int IDXW    = 2 * $clog2(MAX_DIM);
    localparam int BW      = $clog2(SP_NTARGETS);
    localparam int AW      = BW + IDXW;
    localparam int NWORDS  = SP_NTARGETS * NELEM;
    localparam int CNTW    = $clog2(NELEM + 1);

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NELEM);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NELEM - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [4:0]      TAG_C    = 5'b10000;

    typedef enum logic {
        W_IDLE    = 1'b0,
        W_COLLECT = 1'b1
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_STREAM = 2'b01,
        R_DONE   = 2'b10
    } rstate_t;

    logic [BUS_WIDTH-1:0]   r_mem [NWORDS];

    wstate_t                r_wstate;
    wstate_t                w_wstate_nxt;
    logic [BW-1:0]          r_cur_bank;
    logic [BW-1:0]          w_cur_bank_nxt;
    logic [CNTW-1:0]        r_cnt;
    logic [CNTW-1:0]        w_cnt_nxt;
    logic [CNTW-1:0]        w_cnt_mid;
    logic                   w_collect_mid;
    logic [SP_NTARGETS-1:0] r_bank_valid;
    logic [SP_NTARGETS-1:0] w_bank_valid_nxt;
    logic                   r_err;
    logic                   w_err_set;
    logic                   w_mem_we;
    logic [AW-1:0]          w_mem_waddr;

    rstate_t                r_rstate;
    rstate_t                w_rstate_nxt;
    logic [BW-1:0]          r_rd_bank;
    logic [BW-1:0]          w_rd_bank_nxt;
    logic                   r_rd_bank_ok;
    logic                   w_rd_bank_ok_nxt;
    logic [IDXW-1:0]        r_ridx;
    logic [IDXW-1:0]        w_ridx_nxt;
    logic [BUS_WIDTH-1:0]   r_rd_data;
    logic [BUS_WIDTH-1:0]   w_rd_data_nxt;
    logic                   r_rd_valid;
    logic                   w_rd_valid_nxt;
    logic                   r_finished;
    logic                   w_finished_nxt;

    logic [BUS_WIDTH-1:0]   r_host_data;
    logic                   r_host_valid;

    logic                   w_wr_accept;
    logic                   w_bad_tag;
    logic [IDXW-1:0]        w_wr_idx;
    logic                   w_unused_addr;

    assign w_wr_accept   = sp.wr_en_i && (sp.wr_addr_i[4:0] == TAG_C);
    assign w_bad_tag     = sp.wr_en_i && (sp.wr_addr_i[4:0] != TAG_C);
    assign w_wr_idx      = sp.wr_addr_i[5 +: IDXW];
    assign w_unused_addr = ^sp.wr_addr_i[ADDR_WIDTH-1:5+IDXW];

    // Write FSM next state: a burst latches its bank on the first accepted word;
    // finish_mul_i is judged on the count that includes any same-cycle write.
    always_comb begin
        w_cur_bank_nxt   = r_cur_bank;
        w_cnt_mid        = r_cnt;
        w_collect_mid    = (r_wstate == W_COLLECT);
        w_bank_valid_nxt = r_bank_valid;
        w_err_set        = w_bad_tag;
        w_mem_we         = 1'b0;
        w_mem_waddr      = {r_cur_bank, w_wr_idx};
        w_wstate_nxt     = r_wstate;
        w_cnt_nxt        = r_cnt;
        case (r_wstate)
            W_IDLE: begin
                if (w_wr_accept) begin
                    w_cur_bank_nxt                 = sp.wr_bank_i;
                    w_bank_valid_nxt[sp.wr_bank_i] = 1'b0;
                    w_mem_we                       = 1'b1;
                    w_mem_waddr                    = {sp.wr_bank_i, w_wr_idx};
                    w_cnt_mid                      = CNT_ONE;
                    w_collect_mid                  = 1'b1;
                end else begin
                    w_collect_mid = 1'b0;
                end
            end
            W_COLLECT: begin
                if (w_wr_accept) begin
                    w_mem_we = 1'b1;
                    if (r_cnt == CNT_FULL) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_cnt_mid = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_mem_we = 1'b0;
                end
            end
            default: begin
                w_collect_mid = 1'b0;
                w_cnt_mid     = '0;
            end
        endcase
        if (sp.finish_mul_i && w_collect_mid) begin
            w_wstate_nxt = W_IDLE;
            w_cnt_nxt    = '0;
            if (w_cnt_mid == CNT_FULL) begin
                w_bank_valid_nxt[w_cur_bank_nxt] = 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end else begin
            w_wstate_nxt = w_collect_mid ? W_COLLECT : W_IDLE;
            w_cnt_nxt    = w_cnt_mid;
        end
    end

    // Write FSM state and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate     <= W_IDLE;
            r_cur_bank   <= '0;
            r_cnt        <= '0;
            r_bank_valid <= '0;
            r_err        <= 1'b0;
        end else begin
            r_wstate     <= w_wstate_nxt;
            r_cur_bank   <= w_cur_bank_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bank_valid <= w_bank_valid_nxt;
            r_err        <= r_err | w_err_set;
        end
    end

    // Result storage; reads elsewhere sample the pre-edge contents, so a
    // same-cycle read of the word being written returns the old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_mem_waddr] <= sp.wr_data_i;
        end
    end

    // Read FSM next state and registered stream outputs. Bank validity is
    // latched at stream start so an invalid bank streams zeros (no-bias mode).
    always_comb begin
        w_rstate_nxt     = r_rstate;
        w_rd_bank_nxt    = r_rd_bank;
        w_rd_bank_ok_nxt = r_rd_bank_ok;
        w_ridx_nxt       = r_ridx;
        w_rd_data_nxt    = r_rd_data;
        w_rd_valid_nxt   = 1'b0;
        w_finished_nxt   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (sp.rd_req_i) begin
                    w_rd_bank_nxt    = sp.rd_bank_i;
                    w_rd_bank_ok_nxt = r_bank_valid[sp.rd_bank_i];
                    w_ridx_nxt       = '0;
                    w_rstate_nxt     = R_STREAM;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_STREAM: begin
                if (!sp.rd_req_i) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = r_rd_bank_ok ? r_mem[{r_rd_bank, r_ridx}] : '0;
                    if (r_ridx == IDX_LAST) begin
                        w_ridx_nxt   = '0;
                        w_rstate_nxt = R_DONE;
                    end else begin
                        w_ridx_nxt = r_ridx + IDX_ONE;
                    end
                end
            end
            R_DONE: begin
                if (sp.rd_req_i) begin
                    w_finished_nxt = 1'b1;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // Read FSM state and stream output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate     <= R_IDLE;
            r_rd_bank    <= '0;
            r_rd_bank_ok <= 1'b0;
            r_ridx       <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_finished   <= 1'b0;
        end else begin
            r_rstate     <= w_rstate_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_rd_bank_ok <= w_rd_bank_ok_nxt;
            r_ridx       <= w_ridx_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_finished   <= w_finished_nxt;
        end
    end

    // Host readback: data holds its last value when no read is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_host_data  <= '0;
            r_host_valid <= 1'b0;
        end else begin
            r_host_valid <= sp.host_rd_en_i;
            if (sp.host_rd_en_i) begin
                r_host_data <= r_mem[sp.host_addr_i];
            end else begin
                r_host_data <= r_host_data;
            end
        end
    end

    assign sp.rd_data_o       = r_rd_data;
    assign sp.rd_valid_o      = r_rd_valid;
    assign sp.finished_c_o    = r_finished;
    assign sp.host_rd_data_o  = r_host_data;
    assign sp.host_rd_valid_o = r_host_valid;
    assign sp.bank_valid_o    = r_bank_valid;
    assign sp.err_o           = r_err;
endmodule

// File: tb/tb_matmul_result_scratchpad.sv
// Self-checking bench for matmul_result_scratchpad: directed scenarios plus
// randomized bursts checked against a burst-level behavioural model.
module tb_matmul_result_scratchpad;
    localparam int NELEM = 4;
    localparam int NB    = 4;
    localparam logic [4:0] TAG_C = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [NB*NELEM];
    logic [NB-1:0] model_valid;
    logic model_err;
    bit   m_in_burst;
    int   m_cur;
    int   m_cnt;
    logic [15:0] got_q [$];

    matmul_result_scratchpad_if #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .SP_NTARGETS(4)) sp ();

    matmul_result_scratchpad #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .SP_NTARGETS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sp    (sp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sp.wr_en_i      = 1'b0;
        sp.wr_addr_i    = 32'h0;
        sp.wr_data_i    = 16'h0;
        sp.wr_bank_i    = 2'd0;
        sp.finish_mul_i = 1'b0;
        sp.rd_req_i     = 1'b0;
        sp.rd_bank_i    = 2'd0;
        sp.host_rd_en_i = 1'b0;
        sp.host_addr_i  = 4'd0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NB*NELEM; i++) model_mem[i] = 16'h0;
        model_valid = '0;
        model_err   = 1'b0;
        m_in_burst  = 1'b0;
        m_cnt       = 0;
    endtask

    // One-cycle write; the model applies the burst rules at word level.
    task automatic write_word(input logic [1:0] bank, input logic [1:0] idx,
                              input logic [15:0] data, input logic [4:0] tag);
        logic [31:0] a;
        a = $urandom();
        a[4:0] = tag;
        a[6:5] = idx;
        sp.wr_en_i   = 1'b1;
        sp.wr_addr_i = a;
        sp.wr_data_i = data;
        sp.wr_bank_i = bank;
        tick();
        sp.wr_en_i = 1'b0;
        if (tag == TAG_C) begin
            if (!m_in_burst) begin
                m_in_burst = 1'b1;
                m_cur = int'(bank);
                m_cnt = 0;
                model_valid[m_cur] = 1'b0;
            end
            model_mem[m_cur*NELEM + int'(idx)] = data;
            if (m_cnt == NELEM) model_err = 1'b1;
            else m_cnt++;
        end else begin
            model_err = 1'b1;
        end
    endtask

    task automatic finish_pulse();
        sp.finish_mul_i = 1'b1;
        tick();
        sp.finish_mul_i = 1'b0;
        if (m_in_burst) begin
            if (m_cnt == NELEM) model_valid[m_cur] = 1'b1;
            else model_err = 1'b1;
            m_in_burst = 1'b0;
        end
    endtask

    task automatic host_read(input logic [3:0] a, output logic [15:0] d, output logic v);
        sp.host_rd_en_i = 1'b1;
        sp.host_addr_i  = a;
        tick();
        sp.host_rd_en_i = 1'b0;
        d = sp.host_rd_data_o;
        v = sp.host_rd_valid_o;
    endtask

    // Holds rd_req_i until finished_c_o (or a cycle budget); rd_req_i stays high.
    task automatic run_stream(input logic [1:0] bank, output int nvalid, output bit fin_seen);
        got_q.delete();
        nvalid   = 0;
        fin_seen = 1'b0;
        sp.rd_bank_i = bank;
        sp.rd_req_i  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            sp.rd_bank_i = 2'($urandom());
            if (sp.rd_valid_o) begin
                got_q.push_back(sp.rd_data_o);
                nvalid++;
            end
            if (sp.finished_c_o) begin
                fin_seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic v;
        checks++; if (sp.bank_valid_o !== 4'b0000) begin failures++; $display("FAIL reset_bank_valid: got %b expected 0000", sp.bank_valid_o); end
        checks++; if (sp.err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", sp.err_o); end
        checks++; if ({sp.rd_valid_o, sp.finished_c_o, sp.host_rd_valid_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {sp.rd_valid_o, sp.finished_c_o, sp.host_rd_valid_o}); end
        checks++; if ({sp.rd_data_o, sp.host_rd_data_o} !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", {sp.rd_data_o, sp.host_rd_data_o}); end
        host_read({2'd0, 2'd3}, d, v);
        checks++; if (v !== 1'b1 || d !== 16'h0000) begin failures++; $display("FAIL reset_host_read: got v=%b d=%h expected v=1 d=0000", v, d); end
    endtask

    task automatic test_write_burst();
        logic [15:0] vals [4];
        logic [15:0] d;
        logic v;
        vals = '{16'h0011, 16'h0022, 16'hFF00, 16'h7FFF};
        for (int i = 0; i < NELEM; i++) write_word(2'd2, 2'(i), vals[i], TAG_C);
        checks++; if (sp.bank_valid_o !== 4'b0000) begin failures++; $display("FAIL burst_valid_early: got %b expected 0000", sp.bank_valid_o); end
        finish_pulse();
        checks++; if (sp.bank_valid_o !== model_valid) begin failures++; $display("FAIL burst_valid: got %b expected %b", sp.bank_valid_o, model_valid); end
        for (int i = 0; i < NELEM; i++) begin
            host_read({2'd2, 2'(i)}, d, v);
            checks++; if (v !== 1'b1 || d !== model_mem[2*NELEM + i]) begin failures++; $display("FAIL burst_host_read%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, model_mem[2*NELEM + i]); end
        end
        tick();
        checks++; if (sp.host_rd_valid_o !== 1'b0 || sp.host_rd_data_o !== 16'h7FFF) begin failures++; $display("FAIL host_hold: got v=%b d=%h expected v=0 d=7fff", sp.host_rd_valid_o, sp.host_rd_data_o); end
    endtask

    task automatic test_stream(input logic [1:0] bank, input string name);
        int n;
        bit fin;
        logic [15:0] exp;
        run_stream(bank, n, fin);
        checks++; if (n != NELEM || !fin) begin failures++; $display("FAIL %s_count: got n=%0d fin=%0d expected n=%0d fin=1", name, n, fin, NELEM); end
        for (int i = 0; i < n && i < NELEM; i++) begin
            exp = model_valid[bank] ? model_mem[int'(bank)*NELEM + i] : 16'h0;
            checks++; if (got_q[i] !== exp) begin failures++; $display("FAIL %s_word%0d: got %h expected %h", name, i, got_q[i], exp); end
        end
        tick();
        tick();
        checks++; if (sp.finished_c_o !== 1'b1 || sp.rd_valid_o !== 1'b0) begin failures++; $display("FAIL %s_done_hold: got fin=%b v=%b expected fin=1 v=0", name, sp.finished_c_o, sp.rd_valid_o); end
        sp.rd_req_i = 1'b0;
        tick();
        checks++; if (sp.finished_c_o !== 1'b0) begin failures++; $display("FAIL %s_done_release: got fin=%b expected 0", name, sp.finished_c_o); end
    endtask

    task automatic test_rdw();
        logic [15:0] old1, old0, newd, d;
        logic v;
        bit fin;
        old1 = model_mem[2*NELEM + 1];
        sp.rd_bank_i = 2'd2;
        sp.rd_req_i  = 1'b1;
        tick();
        tick();
        checks++; if (sp.rd_valid_o !== 1'b1 || sp.rd_data_o !== model_mem[2*NELEM]) begin failures++; $display("FAIL rdw_word0: got v=%b d=%h expected v=1 d=%h", sp.rd_valid_o, sp.rd_data_o, model_mem[2*NELEM]); end
        write_word(2'd2, 2'd1, 16'h1234, TAG_C);
        checks++; if (sp.rd_valid_o !== 1'b1 || sp.rd_data_o !== old1) begin failures++; $display("FAIL rdw_stream_old: got v=%b d=%h expected v=1 d=%h", sp.rd_valid_o, sp.rd_data_o, old1); end
        checks++; if (sp.bank_valid_o !== model_valid) begin failures++; $display("FAIL rdw_valid_clear: got %b expected %b", sp.bank_valid_o, model_valid); end
        sp.rd_req_i = 1'b0;
        tick();
        checks++; if (sp.rd_valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b expected 0", sp.rd_valid_o); end
        fin = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (sp.finished_c_o || sp.rd_valid_o) fin = 1'b1;
        end
        checks++; if (fin) begin failures++; $display("FAIL abort_no_finish: got activity=1 expected 0"); end
        host_read({2'd2, 2'd1}, d, v);
        checks++; if (d !== model_mem[2*NELEM + 1]) begin failures++; $display("FAIL rdw_host_new: got %h expected %h", d, model_mem[2*NELEM + 1]); end
        old0 = model_mem[2*NELEM];
        newd = 16'($urandom());
        sp.host_rd_en_i = 1'b1;
        sp.host_addr_i  = {2'd2, 2'd0};
        write_word(2'd2, 2'd0, newd, TAG_C);
        sp.host_rd_en_i = 1'b0;
        checks++; if (sp.host_rd_data_o !== old0) begin failures++; $display("FAIL rdw_host_old: got %h expected %h", sp.host_rd_data_o, old0); end
        write_word(2'd0, 2'd2, 16'($urandom()), TAG_C);
        write_word(2'd3, 2'd3, 16'($urandom()), TAG_C);
        finish_pulse();
        checks++; if (sp.bank_valid_o !== model_valid || sp.err_o !== model_err) begin failures++; $display("FAIL rdw_recommit: got bv=%b err=%b expected bv=%b err=%b", sp.bank_valid_o, sp.err_o, model_valid, model_err); end
        host_read({2'd2, 2'd0}, d, v);
        checks++; if (d !== newd) begin failures++; $display("FAIL rdw_host_after: got %h expected %h", d, newd); end
    endtask

    task automatic test_random();
        int perm [4];
        logic [1:0] b;
        logic [3:0] a;
        logic [15:0] d;
        logic v;
        for (int it = 0; it < 6; it++) begin
            perm = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            b = 2'($urandom());
            for (int i = 0; i < NELEM; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                write_word((i == 0) ? b : 2'($urandom()), 2'(perm[i]), 16'($urandom()), TAG_C);
            end
            finish_pulse();
            checks++; if (sp.bank_valid_o !== model_valid || sp.err_o !== model_err) begin failures++; $display("FAIL rand_commit%0d: got bv=%b err=%b expected bv=%b err=%b", it, sp.bank_valid_o, sp.err_o, model_valid, model_err); end
            test_stream(2'($urandom()), "rand_stream");
            for (int k = 0; k < 3; k++) begin
                a = 4'($urandom());
                host_read(a, d, v);
                checks++; if (v !== 1'b1 || d !== model_mem[a]) begin failures++; $display("FAIL rand_host: addr %0d got v=%b d=%h expected v=1 d=%h", a, v, d, model_mem[a]); end
            end
        end
    endtask

    task automatic test_bad_tag();
        logic [15:0] d;
        logic v;
        apply_reset();
        write_word(2'd0, 2'd0, 16'hBEEF, 5'b00100);
        checks++; if (sp.err_o !== model_err) begin failures++; $display("FAIL bad_tag_err: got %b expected %b", sp.err_o, model_err); end
        host_read({2'd0, 2'd0}, d, v);
        checks++; if (d !== model_mem[0]) begin failures++; $display("FAIL bad_tag_mem: got %h expected %h", d, model_mem[0]); end
    endtask

    task automatic test_short_burst();
        logic [15:0] d;
        logic v;
        apply_reset();
        for (int i = 0; i < 3; i++) write_word(2'd3, 2'(i), 16'($urandom()), TAG_C);
        checks++; if (sp.err_o !== 1'b0) begin failures++; $display("FAIL short_err_early: got %b expected 0", sp.err_o); end
        finish_pulse();
        checks++; if (sp.err_o !== model_err || sp.bank_valid_o !== model_valid) begin failures++; $display("FAIL short_burst: got err=%b bv=%b expected err=%b bv=%b", sp.err_o, sp.bank_valid_o, model_err, model_valid); end
        host_read({2'd3, 2'd1}, d, v);
        checks++; if (d !== model_mem[3*NELEM + 1]) begin failures++; $display("FAIL short_mem: got %h expected %h", d, model_mem[3*NELEM + 1]); end
    endtask

    task automatic test_reset_midburst();
        logic [15:0] d;
        logic v;
        int bad;
        apply_reset();
        for (int i = 0; i < NELEM; i++) write_word(2'd0, 2'(i), 16'($urandom()) | 16'h0001, TAG_C);
        finish_pulse();
        write_word(2'd1, 2'd0, 16'hA5A5, TAG_C);
        write_word(2'd1, 2'd1, 16'h5A5A, TAG_C);
        apply_reset();
        checks++; if (sp.bank_valid_o !== model_valid || sp.err_o !== model_err) begin failures++; $display("FAIL midburst_reset: got bv=%b err=%b expected bv=%b err=%b", sp.bank_valid_o, sp.err_o, model_valid, model_err); end
        finish_pulse();
        checks++; if (sp.bank_valid_o !== model_valid || sp.err_o !== model_err) begin failures++; $display("FAIL midburst_finish_idle: got bv=%b err=%b expected bv=%b err=%b", sp.bank_valid_o, sp.err_o, model_valid, model_err); end
        bad = 0;
        for (int i = 0; i < NB*NELEM; i++) begin
            host_read(4'(i), d, v);
            if (d !== model_mem[i]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midburst_mem_clear: got %0d nonzero words expected 0", bad); end
    endtask

    initial begin
        idle_inputs();
        apply_reset();
        test_reset();
        test_write_burst();
        test_stream(2'd2, "stream_bank2");
        test_stream(2'd1, "nobias_bank1");
        test_rdw();
        test_random();
        test_bad_tag();
        test_short_burst();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matmul_result_scratchpad.md
Name: matmul_result_scratchpad

Overview:
- Downstream neighbour of the matmul calc unit.
- Captures the result stream the calc unit emits (write enable, address with OPERAND_C tag, element data) into one of SP_NTARGETS banks. Each bank holds MAX_DIM*MAX_DIM BUS_WIDTH words.
- Serves a stored bank back to the calc unit as the C-bias stream, using the get_matC/finished_c handshake.
- Exposes a 1-cycle-latency host read port for result readback.

Parameters:
- DATA_WIDTH, 8: element width of A/B operands.
- BUS_WIDTH, 16: word width; result/bias element width.
- ADDR_WIDTH, 32: write address width.
- SP_NTARGETS, 4: number of result banks (power of 2).
- Derived localparams: MAX_DIM = BUS_WIDTH/DATA_WIDTH; NELEM = MAX_DIM*MAX_DIM; IDXW = 2*$clog2(MAX_DIM); BW = $clog2(SP_NTARGETS).

Ports:
- clk_i, in, 1: clock. Single clock domain.
- rst_i, in, 1: reset. Synchronous, active-high.
- wr_en_i, in, 1: result write strobe from calc unit.
- wr_addr_i, in, ADDR_WIDTH: [4:0] operand tag; [5+:IDXW] element index.
- wr_data_i, in, BUS_WIDTH: result element.
- wr_bank_i, in, BW: destination bank; sampled on first write of a burst.
- finish_mul_i, in, 1: end-of-result pulse from calc unit.
- rd_req_i, in, 1: level request for the C-bias stream (calc get_matC).
- rd_bank_i, in, BW: bank to stream; sampled at stream start.
- rd_data_o, out, BUS_WIDTH: streamed bias element.
- rd_valid_o, out, 1: rd_data_o valid this cycle.
- finished_c_o, out, 1: stream complete; level.
- host_rd_en_i, in, 1: host read strobe.
- host_addr_i, in, BW+IDXW: {bank, element index}.
- host_rd_data_o, out, BUS_WIDTH: host read data.
- host_rd_valid_o, out, 1: host data valid.
- bank_valid_o, out, SP_NTARGETS: bank holds a complete result.
- err_o, out, 1: sticky error flag.

Behaviour:
- Reset (rst_i high at posedge): all memory words 0; bank_valid_o 0; err_o 0; rd_data_o, rd_valid_o, finished_c_o, host_rd_data_o, host_rd_valid_o 0; both FSMs to idle; counters 0. Reset mid-burst or mid-stream aborts with no commit.
- Write FSM, states W_IDLE / W_COLLECT:
  - Accepted write: wr_en_i=1 and wr_addr_i[4:0]==5'b10000. A write with any other tag is ignored and sets err_o.
  - W_IDLE + accepted write: latch wr_bank_i as cur_bank; clear bank_valid_o[cur_bank]; store word; cnt=1; go to W_COLLECT.
  - W_COLLECT + accepted write: store word at mem[cur_bank][idx]; cnt+1, saturating at NELEM. A write arriving when cnt==NELEM sets err_o and is still stored.
  - finish_mul_i in W_COLLECT: if cnt==NELEM, set bank_valid_o[cur_bank] next cycle; otherwise set err_o and leave the bank invalid. Go to W_IDLE.
  - finish_mul_i in W_IDLE: ignored.
  - Write and finish_mul_i in the same cycle: the write counts first, then the finish check applies.
- Read FSM, states R_IDLE / R_STREAM / R_DONE:
  - R_IDLE + rd_req_i: latch rd_bank_i; ridx=0; go to R_STREAM.
  - R_STREAM: each cycle rd_data_o = mem[bank][ridx] (registered) and rd_valid_o=1. First valid word appears the cycle after entry; NELEM consecutive valid cycles.
  - If the bank is not valid, stream zeros with identical timing (no-bias mode).
  - After index NELEM-1, go to R_DONE.
  - R_DONE: finished_c_o=1, rd_valid_o=0. Hold until rd_req_i=0, then finished_c_o=0 and go to R_IDLE.
  - rd_req_i dropped during R_STREAM: abort to R_IDLE; rd_valid_o=0 next cycle; finished_c_o never asserts.
- Host port: host_rd_en_i at cycle t gives host_rd_data_o = mem[host_addr_i] and host_rd_valid_o=1 at t+1; otherwise host_rd_valid_o=0 and data holds its last value. No bank-valid check.
- Read-during-write, same word, same cycle: both read ports return the pre-write value. The new value is visible from the next read.
- Write FSM and read FSM run independently; a write and a stream may be active simultaneously.
- err_o clears only on reset.

Test Plan (defaults, NELEM=4):
- Reset then host read of bank 0 idx 3 -> host_rd_data_o=0x0000 at t+1; bank_valid_o=4'b0000; err_o=0.
- Writes idx0..3 = 0x0011, 0x0022, 0xFF00, 0x7FFF to bank 2 with tag 5'b10000, then finish_mul_i -> bank_valid_o=4'b0100 one cycle later; host reads return the same four values.
- rd_req_i held with rd_bank_i=2 -> rd_valid_o high for exactly 4 cycles carrying 0x0011, 0x0022, 0xFF00, 0x7FFF; then finished_c_o=1 until rd_req_i drops; back to idle next cycle.
- rd_req_i on invalid bank 1 -> four valid zero words, then finished_c_o.
- Only 3 writes then finish_mul_i -> err_o=1; bank stays invalid. Separately, a write with tag 5'b00100 -> ignored; err_o=1; memory unchanged.
- Stream bank 2 while rewriting bank 2 idx1 to 0x1234 in the cycle idx1 is read -> stream shows 0x0022; a later host read shows 0x1234. bank_valid_o[2] clears at the first write of the burst; rd_req_i dropped after 2 words -> no finished_c_o.
- Reset asserted mid-burst (after 2 writes) -> bank_valid_o=0; all memory words 0.
